// File: rtl/alu_pkg.sv
// Shared ALU opcodes, RV decode constants, issue FSM states and decode payload for alu_issue_ctrl.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_IDLE = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam int unsigned IMM_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0]       alu_code;
        logic             use_imm;
        logic [IMM_W-1:0] imm;
        logic             illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decode: instr -> {alu_code, use_imm, imm, illegal}.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign opcode      = instr_i[6:0];
    assign funct3      = instr_i[14:12];
    assign funct7      = instr_i[31:25];
    assign unused_bits = ^{instr_i[19:15], instr_i[11:7]};

    always_comb begin
        dec_o          = '0;
        dec_o.alu_code = ALU_IDLE;
        dec_o.imm      = instr_i[31:20];
        dec_o.illegal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  begin dec_o.alu_code = ALU_ADD; dec_o.illegal = 1'b0; end
                        F3_AND:  begin dec_o.alu_code = ALU_AND; dec_o.illegal = 1'b0; end
                        F3_OR:   begin dec_o.alu_code = ALU_OR;  dec_o.illegal = 1'b0; end
                        default: ;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                    dec_o.alu_code = ALU_SUB;
                    dec_o.illegal  = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_o.use_imm = 1'b1;
                case (funct3)
                    F3_ADD:  begin dec_o.alu_code = ALU_ADD; dec_o.illegal = 1'b0; end
                    F3_AND:  begin dec_o.alu_code = ALU_AND; dec_o.illegal = 1'b0; end
                    F3_OR:   begin dec_o.alu_code = ALU_OR;  dec_o.illegal = 1'b0; end
                    default: dec_o.use_imm = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                // BEQ compares via subtraction; zero flag means taken
                if (funct3 == F3_BEQ) begin
                    dec_o.alu_code = ALU_SUB;
                    dec_o.illegal  = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: request accept, one-cycle ALU drive, registered response.
// Optional ALU_OVF_TRAP_EN adds the rsp_overflow output.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_instr,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    output logic [3:0]       alu_code,
    output logic [XLEN-1:0]  alu_src1,
    output logic [XLEN-1:0]  alu_src2,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal,
`ifdef ALU_OVF_TRAP_EN
    output logic             rsp_overflow,
`endif
    output logic [CNT_W-1:0] op_count
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [3:0]        code_q, code_d;
    logic [XLEN-1:0]   src1_q, src1_d;
    logic [XLEN-1:0]   src2_q, src2_d;
    logic              illegal_q, illegal_d;
    logic              ovf_en_q, ovf_en_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              rsp_ill_q, rsp_ill_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dec_t              dec;
    logic [XLEN-1:0]   imm_sext;

    alu_issue_decode u_decode (
        .instr_i (req_instr),
        .dec_o   (dec)
    );

    assign imm_sext = {{(XLEN-IMM_W){dec.imm[IMM_W-1]}}, dec.imm};

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        illegal_d = illegal_q;
        ovf_en_d  = ovf_en_q;
        result_d  = result_q;
        zero_d    = zero_q;
        rsp_ill_d = rsp_ill_q;
        rsp_ovf_d = rsp_ovf_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d   = EXEC;
                    code_d    = dec.alu_code;
                    src1_d    = req_rs1;
                    src2_d    = dec.use_imm ? imm_sext : req_rs2;
                    illegal_d = dec.illegal;
                    // overflow is meaningful only for arithmetic ops, not BEQ compares
                    ovf_en_d  = (dec.alu_code == ALU_ADD || dec.alu_code == ALU_SUB) &&
                                (req_instr[6:0] != OPC_BRANCH);
                end
            end
            EXEC: begin
                state_d   = RESP;
                code_d    = ALU_IDLE;
                result_d  = illegal_q ? '0 : alu_result;
                zero_d    = !illegal_q && alu_zero;
                rsp_ill_d = illegal_q;
                rsp_ovf_d = ovf_en_q && alu_overflow;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            code_q      <= ALU_IDLE;
            src1_q      <= '0;
            src2_q      <= '0;
            illegal_q   <= 1'b0;
            ovf_en_q    <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            rsp_ill_q   <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            code_q      <= code_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            illegal_q   <= illegal_d;
            ovf_en_q    <= ovf_en_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            rsp_ill_q   <= rsp_ill_d;
            rsp_ovf_q   <= rsp_ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign alu_code    = code_q;
    assign alu_src1    = src1_q;
    assign alu_src2    = src2_q;
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign rsp_illegal = rsp_ill_q;
    assign op_count    = cnt_q;

`ifdef ALU_OVF_TRAP_EN
    assign rsp_overflow = rsp_ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ^{alu_overflow, rsp_ovf_q};
`endif

endmodule
